// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the HI/LO pair for MFHI/MFLO.
// Ports: clk, clr_n (async low); start/op/rs_data/rt_data launch an op;
//   hi_we/lo_we/wdata are MTHI/MTLO; busy, done pulse, hi, lo are outputs.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIX
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [CW-1:0]    r_cnt;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_opnd;
   logic [WIDTH-1:0] r_rs;
   logic             r_div;
   logic             r_sa;
   logic             r_sb;
   logic             r_dz;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic             r_busy;
   logic             r_done;

   logic             w_signed;
   logic             w_sa;
   logic             w_sb;
   logic [WIDTH-1:0] w_ma;
   logic [WIDTH-1:0] w_mb;
   logic [WIDTH:0]   w_msum;
   logic [WIDTH:0]   w_rsh;
   logic             w_ok;
   logic [WIDTH-1:0] w_sub;
   logic [2*WIDTH-1:0] w_mul_nxt;
   logic [2*WIDTH-1:0] w_div_nxt;
   logic             w_neg;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0] w_quo;
   logic [WIDTH-1:0] w_rem;

   assign w_signed = ~op[0];
   assign w_sa     = w_signed & rs_data[WIDTH-1];
   assign w_sb     = w_signed & rt_data[WIDTH-1];
   assign w_ma     = w_sa ? -rs_data : rs_data;
   assign w_mb     = w_sb ? -rt_data : rt_data;

   // Multiply: acc = {partial, multiplier}; add into the top, shift right.
   assign w_msum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                    + (r_acc[0] ? {1'b0, r_opnd} : '0);
   assign w_mul_nxt = {w_msum, r_acc[WIDTH-1:1]};

   // Divide: acc = {remainder, dividend->quotient}; restoring step.
   // The difference fits WIDTH bits whenever the trial subtract succeeds.
   assign w_rsh     = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
   assign w_ok      = (w_rsh >= {1'b0, r_opnd});
   assign w_sub     = w_rsh[WIDTH-1:0] - r_opnd;
   assign w_div_nxt = {w_ok ? w_sub : w_rsh[WIDTH-1:0],
                       r_acc[WIDTH-2:0], w_ok};

   assign w_neg  = r_sa ^ r_sb;
   assign w_prod = w_neg ? -r_acc : r_acc;
   assign w_quo  = w_neg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
   assign w_rem  = r_sa ? -r_acc[2*WIDTH-1:WIDTH]
                        : r_acc[2*WIDTH-1:WIDTH];

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (start) w_next = S_CALC;
         S_CALC:  if (r_cnt == CW'(WIDTH-1)) w_next = S_FIX;
         S_FIX:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_cnt  <= '0;
         r_acc  <= '0;
         r_opnd <= '0;
         r_rs   <= '0;
         r_div  <= 1'b0;
         r_sa   <= 1'b0;
         r_sb   <= 1'b0;
         r_dz   <= 1'b0;
         r_hi   <= '0;
         r_lo   <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_busy <= (w_next != S_IDLE);
         r_done <= (r_state == S_FIX);
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_cnt  <= '0;
                  r_div  <= op[1];
                  r_sa   <= w_sa;
                  r_sb   <= w_sb;
                  r_dz   <= (rt_data == '0);
                  r_rs   <= rs_data;
                  r_acc  <= {{WIDTH{1'b0}}, op[1] ? w_ma : w_mb};
                  r_opnd <= op[1] ? w_mb : w_ma;
               end else begin
                  if (hi_we) r_hi <= wdata;
                  if (lo_we) r_lo <= wdata;
               end
            end
            S_CALC: begin
               r_cnt <= r_cnt + 1'b1;
               r_acc <= r_div ? w_div_nxt : w_mul_nxt;
            end
            S_FIX: begin
               if (r_div && r_dz) begin
                  r_hi <= r_rs;
                  r_lo <= '1;
               end else if (r_div) begin
                  r_hi <= w_rem;
                  r_lo <= w_quo;
               end else begin
                  r_hi <= w_prod[2*WIDTH-1:WIDTH];
                  r_lo <= w_prod[WIDTH-1:0];
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed cases plus random ops
// checked against a plain-arithmetic HI/LO model.
module tb_mult_div_unit;

   logic        clk;
   logic        clr_n;
   logic        start;
   logic [1:0]  op;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        hi_we;
   logic        lo_we;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   mult_div_unit #(.WIDTH(32)) dut (
      .clk(clk), .clr_n(clr_n), .start(start), .op(op),
      .rs_data(rs_data), .rt_data(rt_data),
      .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          c0;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   int   busy_run = 0;
   int   done_cnt = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // {hi, lo} from integer arithmetic on the architectural operands.
   function automatic logic [63:0] model(input logic [1:0] o,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
      longint      sa;
      longint      sb2;
      longint      q;
      longint      r;
      logic [63:0] ua;
      logic [63:0] ub;
      logic [63:0] res;
      sa  = longint'($signed(a));
      sb2 = longint'($signed(b));
      ua  = {32'h0, a};
      ub  = {32'h0, b};
      res = '0;
      case (o)
         2'd0: res = 64'(sa * sb2);
         2'd1: res = ua * ub;
         2'd2: begin
            if (b == 0) res = {a, 32'hFFFF_FFFF};
            else begin
               q = sa / sb2;
               r = sa % sb2;
               res = {r[31:0], q[31:0]};
            end
         end
         default: begin
            if (b == 0) res = {a, 32'hFFFF_FFFF};
            else res = {32'(ua % ub), 32'(ua / ub)};
         end
      endcase
      return res;
   endfunction

   // Monitor: compare every done pulse against the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!clr_n) begin
         busy_run = 0;
      end else begin
         if (done) begin
            done_cnt++;
            if (sb.size() == 0) begin
               chk("unexpected_done", {31'h0, done}, 32'h0);
            end else begin
               e = sb.pop_front();
               chk("hi", hi, e.hi);
               chk("lo", lo, e.lo);
               chk("latency", 32'(cyc - e.c0), 32'd33);
               chk("busy_len", 32'(busy_run), 32'd33);
            end
         end
         if (busy) busy_run++;
         else      busy_run = 0;
      end
   end

   // Called at a negedge with the unit idle.
   task automatic launch(input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b);
      exp_t        e;
      logic [63:0] m;
      m     = model(o, a, b);
      e.hi  = m[63:32];
      e.lo  = m[31:0];
      e.c0  = cyc + 1;
      sb.push_back(e);
      start   = 1'b1;
      op      = o;
      rs_data = a;
      rt_data = b;
      @(posedge clk);
      #1;
      start   = 1'b0;
      op      = 2'($urandom);
      rs_data = $urandom;
      rt_data = $urandom;
   endtask

   task automatic wait_done();
      bit got;
      got = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         n_tests++;
         n_fail++;
         $display("FAIL done_timeout: got no done, expected one");
      end
   endtask

   function automatic logic [31:0] pick();
      logic [31:0] v;
      case ($urandom_range(0, 7))
         0:       v = 32'h0;
         1:       v = 32'h8000_0000;
         2:       v = 32'hFFFF_FFFF;
         3:       v = 32'h1;
         default: v = $urandom;
      endcase
      return v;
   endfunction

   initial begin
      clr_n   = 1'b0;
      start   = 1'b0;
      op      = 2'd0;
      rs_data = '0;
      rt_data = '0;
      hi_we   = 1'b0;
      lo_we   = 1'b0;
      wdata   = '0;
      #2;
      chk("rst_hi", hi, 32'h0);
      chk("rst_lo", lo, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_done", {31'h0, done}, 32'h0);
      repeat (2) @(negedge clk);
      clr_n = 1'b1;
      @(negedge clk);

      launch(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done();
      launch(2'd0, 32'hFFFF_FFFD, 32'd5);
      wait_done();
      launch(2'd0, 32'd7, 32'hFFFF_FFFA);
      wait_done();
      launch(2'd2, 32'hFFFF_FFF9, 32'd2);
      wait_done();
      launch(2'd3, 32'd100, 32'd7);
      wait_done();
      launch(2'd3, 32'd5, 32'd0);
      wait_done();
      launch(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done();
      launch(2'd2, 32'hFFFF_FFF9, 32'd0);
      wait_done();

      // A second start mid-operation must be dropped.
      launch(2'd1, 32'd1000, 32'd3);
      repeat (9) @(negedge clk);
      start   = 1'b1;
      op      = 2'd3;
      rs_data = 32'd77;
      rt_data = 32'd5;
      @(negedge clk);
      start = 1'b0;
      wait_done();
      @(negedge clk);
      chk("no_queue_busy", {31'h0, busy}, 32'h0);

      // Abort a DIVU with reset.
      launch(2'd3, 32'd123456, 32'd789);
      repeat (14) @(negedge clk);
      clr_n = 1'b0;
      #2;
      chk("abort_hi", hi, 32'h0);
      chk("abort_lo", lo, 32'h0);
      chk("abort_busy", {31'h0, busy}, 32'h0);
      chk("abort_done", {31'h0, done}, 32'h0);
      sb.delete();
      repeat (2) @(negedge clk);
      clr_n = 1'b1;
      done_cnt = 0;
      repeat (40) @(negedge clk);
      chk("abort_no_done", 32'(done_cnt), 32'd0);

      hi_we = 1'b1;
      wdata = 32'h1234_5678;
      @(posedge clk);
      #1;
      hi_we = 1'b0;
      chk("mthi_hi", hi, 32'h1234_5678);
      chk("mthi_lo", lo, 32'h0);
      @(negedge clk);
      lo_we = 1'b1;
      wdata = 32'hCAFE_0001;
      @(posedge clk);
      #1;
      lo_we = 1'b0;
      chk("mtlo_lo", lo, 32'hCAFE_0001);
      chk("mtlo_hi", hi, 32'h1234_5678);
      @(negedge clk);
      hi_we = 1'b1;
      lo_we = 1'b1;
      wdata = 32'h0BAD_F00D;
      @(posedge clk);
      #1;
      hi_we = 1'b0;
      lo_we = 1'b0;
      chk("mtboth_hi", hi, 32'h0BAD_F00D);
      chk("mtboth_lo", lo, 32'h0BAD_F00D);
      @(negedge clk);

      // MTHI/MTLO in the start cycle and while busy are ignored.
      hi_we = 1'b1;
      lo_we = 1'b1;
      wdata = 32'hDEAD_DEAD;
      launch(2'd1, 32'd3, 32'd4);
      chk("start_prio_hi", hi, 32'h0BAD_F00D);
      wdata = 32'hBEEF_BEEF;
      repeat (10) @(negedge clk);
      chk("busy_we_hi", hi, 32'h0BAD_F00D);
      chk("busy_we_lo", lo, 32'h0BAD_F00D);
      hi_we = 1'b0;
      lo_we = 1'b0;
      wait_done();

      // Random ops, each launched in the done cycle of the previous one.
      for (int i = 0; i < 40; i++) begin
         launch(2'($urandom_range(0, 3)), pick(), pick());
         wait_done();
      end
      repeat (3) @(negedge clk);
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
